line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
Sequencer for the multi-line pixel buffer in the video pipeline. Tracks column and row of the incoming pixel stream and generates the write address and write enable for the line memories. Reports when a full BUF_DEPTH-line window is available, with border flags for downstream window filters. Sits between the video-timing front end and the line buffer; detects malformed lines and frames.

Parameters:
SCREENWIDTH, 1600, active pixels per line
SCREENHEIGHT, 900, active lines per frame
BUF_DEPTH, 3, lines in window (current line + BUF_DEPTH-1 stored lines); ≥1
ADDR_W, 11, address/column width; 2^ADDR_W > SCREENWIDTH
ROW_W, 11, row counter width; 2^ROW_W > SCREENHEIGHT

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
vs_i  in  1  frame-start pulse
dv_i  in  1  pixel valid
line_end_i  in  1  end-of-line pulse
addr_o  out  ADDR_W  line-memory address for current dv_i pixel (= column counter)
we_o  out  1  line-memory write enable
win_dv_o  out  1  full window valid (1 cycle after pixel, matching memory read latency)
row_o  out  ROW_W  index of line being written
first_col_o / last_col_o  out  1  window at column 0 / SCREENWIDTH-1 (aligned with win_dv_o)
first_row_o / last_row_o  out  1  first full window row (row BUF_DEPTH-1) / row SCREENHEIGHT-1 (aligned with win_dv_o)
frame_done_o  out  1  1-cycle pulse after last line of frame
overflow_err_o  out  1  sticky: pixel beyond SCREENWIDTH in a line
short_line_err_o  out  1  sticky: line ended with 0 < col < SCREENWIDTH

Behaviour:
- Reset: state IDLE; col=0, row=0; all outputs 0, including sticky errors.
- FSM states IDLE, FILL, RUN.
  - IDLE: dv_i/line_end_i ignored; we_o=0. On vs_i → FILL, or → RUN if BUF_DEPTH==1.
  - FILL: row < BUF_DEPTH-1. Lines are written, win_dv_o=0. Accepted line end that makes row==BUF_DEPTH-1 → RUN.
  - RUN: writes continue, win_dv_o follows dv_i. Accepted line end with row==SCREENHEIGHT-1 → IDLE, frame_done_o pulses next cycle, row→0.
- vs_i in any state: col=0, row=0, clear sticky errors, enter FILL (RUN if BUF_DEPTH==1). vs_i beats a coincident line_end_i. rst beats everything.
- Column counter:
  - addr_o = col (combinational from register).
  - we_o = dv_i & (state≠IDLE) & (col < SCREENWIDTH).
  - col increments on each written pixel. It saturates at SCREENWIDTH.
  - dv_i at col==SCREENWIDTH: no write, overflow_err_o set next cycle.
- Line end:
  - Accepted only if col>0 (or dv_i in same cycle). Otherwise it is a blanking line: ignored, no row change.
  - dv_i and line_end_i in the same cycle: pixel written at current col, then col→0.
  - Accepted line end: row increments (except RUN last row, see FSM), col→0.
  - If the final pixel count is < SCREENWIDTH, short_line_err_o is set next cycle.
- Window outputs (registered, 1-cycle latency from dv_i):
  - win_dv_o = we_o delayed 1 cycle, qualified by state RUN at the time of the write.
  - first_col_o = delayed (col==0); last_col_o = delayed (col==SCREENWIDTH-1).
  - first_row_o = delayed (row==BUF_DEPTH-1); last_row_o = delayed (row==SCREENHEIGHT-1).
  - All flags are 0 whenever win_dv_o=0.
- Reset mid-line or mid-frame: all counters and state return to IDLE next cycle. No partial window is emitted afterwards.
- Widths: counter compares use full ADDR_W/ROW_W. No wrap-around is possible given saturation.

Test Plan:
Params for all tests: SCREENWIDTH=8, SCREENHEIGHT=4, BUF_DEPTH=3.
1. Reset, then vs_i, then 4 lines of 8 contiguous dv_i pixels + line_end_i each → win_dv_o=0 for lines 0-1. Lines 2-3 give 8 win_dv_o pulses each, 1 cycle after dv_i. addr_o runs 0..7. frame_done_o pulses once after line 3; state IDLE.
2. Same frame: check flags → first_col_o on pixel 0, last_col_o on pixel 7; first_row_o only on line 2, last_row_o only on line 3.
3. Line of 10 pixels → we_o high for 8 cycles only, addr_o holds 8. overflow_err_o=1 until next vs_i.
4. Line of 5 pixels then line_end_i; separately, line_end_i with no pixels → short_line_err_o=1 for the first case. The empty line_end leaves row_o unchanged.
5. dv_i+line_end_i coincident on pixel 7; vs_i+line_end_i coincident → pixel 7 written, col→0, row+1. vs_i wins: row_o=0, FILL.
6. rst asserted mid-line 2 → next cycle all outputs 0, IDLE. dv_i ignored until vs_i.

Source files
------------

// File: rtl/line_buffer_ctrl_if.sv
// line_buffer_ctrl_if: pixel stream in, line-memory write and window status out
interface line_buffer_ctrl_if #(parameter int ADDR_W = 11, parameter int ROW_W = 11);
  logic vs_i, dv_i, line_end_i;
  logic [ADDR_W-1:0] addr_o;
  logic [ROW_W-1:0] row_o;
  logic we_o, win_dv_o, first_col_o, last_col_o, first_row_o, last_row_o;
  logic frame_done_o, overflow_err_o, short_line_err_o;
  modport master(
    output vs_i, dv_i, line_end_i,
    input addr_o, we_o, win_dv_o, row_o, first_col_o, last_col_o, first_row_o, last_row_o,
    input frame_done_o, overflow_err_o, short_line_err_o
  );
  modport slave(
    input vs_i, dv_i, line_end_i,
    output addr_o, we_o, win_dv_o, row_o, first_col_o, last_col_o, first_row_o, last_row_o,
    output frame_done_o, overflow_err_o, short_line_err_o
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: column/row sequencer and window-valid generator for a multi-line pixel buffer
module line_buffer_ctrl #(
  parameter int SCREENWIDTH = 1600,
  parameter int SCREENHEIGHT = 900,
  parameter int BUF_DEPTH = 3,
  parameter int ADDR_W = 11,
  parameter int ROW_W = 11
) (
  input logic clk,
  input logic rst,
  line_buffer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam logic [ADDR_W-1:0] WIDTH = ADDR_W'(SCREENWIDTH);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(SCREENWIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREENHEIGHT - 1);
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(BUF_DEPTH - 1);
  localparam state_t START = (BUF_DEPTH == 1) ? RUN : FILL;
  state_t state, state_n;
  logic [ADDR_W-1:0] col, col_n, cnt;
  logic [ROW_W-1:0] row, row_n;
  logic active, we, le_acc, wrap, run_wr, fd_n, ovf_n, short_n;
  // Next-state, counter and error logic; a frame start overrides any coincident line end
  always_comb begin
    active = state != IDLE;
    we = bus.dv_i & active & (col < WIDTH);
    cnt = col + ADDR_W'(we);
    le_acc = bus.line_end_i & active & ((col != '0) | bus.dv_i);
    wrap = le_acc & (state == RUN) & (row == LAST_ROW);
    run_wr = we & (state == RUN);
    state_n = bus.vs_i ? START
            : wrap ? IDLE
            : (le_acc & (state == FILL) & (row + ROW_W'(1) == FIRST_ROW)) ? RUN
            : state;
    col_n = (bus.vs_i | le_acc) ? '0 : cnt;
    row_n = (bus.vs_i | wrap) ? '0 : row + ROW_W'(le_acc);
    fd_n = ~bus.vs_i & wrap;
    ovf_n = ~bus.vs_i & (bus.overflow_err_o | (bus.dv_i & active & (col == WIDTH)));
    short_n = ~bus.vs_i & (bus.short_line_err_o | (le_acc & (cnt < WIDTH)));
  end
  // Sequencer state, counters and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      bus.frame_done_o <= 1'b0;
      bus.overflow_err_o <= 1'b0;
      bus.short_line_err_o <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      bus.frame_done_o <= fd_n;
      bus.overflow_err_o <= ovf_n;
      bus.short_line_err_o <= short_n;
    end
  end
  // Window valid and border flags lag the write by one cycle to line up with memory read data
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.win_dv_o <= 1'b0;
      bus.first_col_o <= 1'b0;
      bus.last_col_o <= 1'b0;
      bus.first_row_o <= 1'b0;
      bus.last_row_o <= 1'b0;
    end else begin
      bus.win_dv_o <= run_wr;
      bus.first_col_o <= run_wr & (col == '0);
      bus.last_col_o <= run_wr & (col == LAST_COL);
      bus.first_row_o <= run_wr & (row == FIRST_ROW);
      bus.last_row_o <= run_wr & (row == LAST_ROW);
    end
  end
  assign bus.addr_o = col;
  assign bus.we_o = we;
  assign bus.row_o = row;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: scoreboard bench for line_buffer_ctrl with an 8x4 screen and 3-line window
module tb_line_buffer_ctrl;
  localparam int W = 8, H = 4, D = 3, ADDR_W = 11, ROW_W = 11;
  typedef struct packed {logic [3:0] f; int c;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0, cycle = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [30:0] all_o;
  line_buffer_ctrl_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus();
  line_buffer_ctrl #(.SCREENWIDTH(W), .SCREENHEIGHT(H), .BUF_DEPTH(D), .ADDR_W(ADDR_W), .ROW_W(ROW_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  assign all_o = {bus.addr_o, bus.we_o, bus.win_dv_o, bus.row_o, bus.first_col_o, bus.last_col_o,
                  bus.first_row_o, bus.last_row_o, bus.frame_done_o, bus.overflow_err_o, bus.short_line_err_o};
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;
  // Window monitor: every win_dv_o pulse must match the oldest expected window, exactly one cycle after its pixel
  always @(negedge clk) begin
    checks++;
    if (bus.win_dv_o) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL win_unexpected: got win_dv_o=1 flags=%b, want no window", {bus.first_col_o, bus.last_col_o, bus.first_row_o, bus.last_row_o});
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.first_col_o, bus.last_col_o, bus.first_row_o, bus.last_row_o} !== mon_e.f || cycle != mon_e.c + 1) begin
          errors++;
          $display("FAIL win_flags: got flags=%b at cycle %0d, want flags=%b at cycle %0d",
                   {bus.first_col_o, bus.last_col_o, bus.first_row_o, bus.last_row_o}, cycle, mon_e.f, mon_e.c + 1);
        end
      end
    end else if ({bus.first_col_o, bus.last_col_o, bus.first_row_o, bus.last_row_o} !== 4'b0) begin
      errors++;
      $display("FAIL flags_idle: got flags=%b with win_dv_o=0, want 0000", {bus.first_col_o, bus.last_col_o, bus.first_row_o, bus.last_row_o});
    end
  end
  task automatic cyc(input logic v, input logic d, input logic l);
    @(posedge clk);
    #1;
    bus.vs_i = v;
    bus.dv_i = d;
    bus.line_end_i = l;
    @(negedge clk);
  endtask
  task automatic pixel(input int p, input int line, input bit run, input logic l);
    cyc(1'b0, 1'b1, l);
    checks += 3;
    if (bus.we_o !== 1'b1) begin errors++; $display("FAIL pixel_we: line %0d pix %0d got %b want 1", line, p, bus.we_o); end
    if (bus.addr_o !== ADDR_W'(p)) begin errors++; $display("FAIL pixel_addr: line %0d got %0d want %0d", line, bus.addr_o, p); end
    if (bus.row_o !== ROW_W'(line)) begin errors++; $display("FAIL pixel_row: pix %0d got %0d want %0d", p, bus.row_o, line); end
    if (run) exp_q.push_back('{f: {p == 0, p == W - 1, line == D - 1, line == H - 1}, c: cycle});
  endtask
  task automatic drained(input string name);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing_windows: got %0d pending, want 0", name, exp_q.size()); end
    exp_q.delete();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (all_o !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.we_o !== 1'b0) begin errors++; $display("FAIL reset_idle_we: got %b want 0", bus.we_o); end
  endtask
  task automatic test_frame();
    cyc(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < H; l++) begin
      for (int p = 0; p < W; p++) pixel(p, l, l >= D - 1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL frame_done_early: line %0d got 1 want 0", l); end
    end
    cyc(1'b0, 1'b1, 1'b0);
    checks += 3;
    if (bus.frame_done_o !== 1'b1) begin errors++; $display("FAIL frame_done: got %b want 1", bus.frame_done_o); end
    if (bus.row_o !== '0) begin errors++; $display("FAIL frame_row_wrap: got %0d want 0", bus.row_o); end
    if (bus.we_o !== 1'b0) begin errors++; $display("FAIL frame_idle_we: got %b want 0", bus.we_o); end
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b want 0", bus.frame_done_o); end
    drained("frame");
  endtask
  task automatic test_overflow();
    cyc(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < W + 2; p++) begin
      cyc(1'b0, 1'b1, 1'b0);
      checks += 3;
      if (bus.we_o !== (p < W)) begin errors++; $display("FAIL ovf_we: pix %0d got %b want %b", p, bus.we_o, p < W); end
      if (bus.addr_o !== ADDR_W'(p < W ? p : W)) begin errors++; $display("FAIL ovf_addr: pix %0d got %0d want %0d", p, bus.addr_o, p < W ? p : W); end
      if (bus.overflow_err_o !== (p > W)) begin errors++; $display("FAIL ovf_flag: pix %0d got %b want %b", p, bus.overflow_err_o, p > W); end
    end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    checks += 3;
    if (bus.overflow_err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_err_o); end
    if (bus.short_line_err_o !== 1'b0) begin errors++; $display("FAIL ovf_not_short: got %b want 0", bus.short_line_err_o); end
    if (bus.row_o !== ROW_W'(1)) begin errors++; $display("FAIL ovf_row: got %0d want 1", bus.row_o); end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow_err_o !== 1'b0) begin errors++; $display("FAIL ovf_clear_vs: got %b want 0", bus.overflow_err_o); end
  endtask
  task automatic test_short_line();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bus.row_o !== '0) begin errors++; $display("FAIL blank_row: got %0d want 0", bus.row_o); end
    if (bus.short_line_err_o !== 1'b0) begin errors++; $display("FAIL blank_short: got %b want 0", bus.short_line_err_o); end
    for (int p = 0; p < 5; p++) pixel(p, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bus.short_line_err_o !== 1'b1) begin errors++; $display("FAIL short_flag: got %b want 1", bus.short_line_err_o); end
    if (bus.row_o !== ROW_W'(1)) begin errors++; $display("FAIL short_row: got %0d want 1", bus.row_o); end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bus.row_o !== ROW_W'(1)) begin errors++; $display("FAIL blank_row_hold: got %0d want 1", bus.row_o); end
    if (bus.short_line_err_o !== 1'b1) begin errors++; $display("FAIL short_sticky: got %b want 1", bus.short_line_err_o); end
  endtask
  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < D; l++)
      for (int p = 0; p < W; p++) pixel(p, l, l >= D - 1, p == W - 1);
    for (int p = 0; p < 3; p++) pixel(p, D, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    checks += 4;
    if (bus.row_o !== '0) begin errors++; $display("FAIL vs_row: got %0d want 0", bus.row_o); end
    if (bus.addr_o !== '0) begin errors++; $display("FAIL vs_col: got %0d want 0", bus.addr_o); end
    if (bus.short_line_err_o !== 1'b0) begin errors++; $display("FAIL vs_short_clear: got %b want 0", bus.short_line_err_o); end
    if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL vs_no_done: got %b want 0", bus.frame_done_o); end
    pixel(0, 0, 1'b0, 1'b0);
    pixel(1, 0, 1'b0, 1'b0);
    drained("b2b");
  endtask
  task automatic test_reset_mid_line();
    cyc(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < D - 1; l++)
      for (int p = 0; p < W; p++) pixel(p, l, 1'b0, p == W - 1);
    for (int p = 0; p < 3; p++) pixel(p, D - 1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_o !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_o); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.we_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle_we: cycle %0d got %b want 0", i, bus.we_o); end
    end
    drained("rst_mid");
    cyc(1'b1, 1'b0, 1'b0);
    pixel(0, 0, 1'b0, 1'b0);
    drained("rst_resume");
  endtask
  initial begin
    bus.vs_i = 1'b0;
    bus.dv_i = 1'b0;
    bus.line_end_i = 1'b0;
    test_reset();
    test_frame();
    test_overflow();
    test_short_line();
    test_back_to_back();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
